// File: rtl/global_buffer_pkg.sv
// Shared GLB types: load-DMA header layout, header-queue defaults and FSM states.
package global_buffer_pkg;

  localparam int unsigned LD_HQ_DEPTH     = 4;
  localparam int unsigned LD_HQ_CNT_WIDTH = 16;
  localparam int unsigned LD_ADDR_WIDTH   = 16;
  localparam int unsigned LD_LEN_WIDTH    = 16;

  typedef struct packed {
    logic                     valid;
    logic [LD_ADDR_WIDTH-1:0] start_addr;
    logic [LD_LEN_WIDTH-1:0]  num_words;
  } dma_ld_header_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    OFFER = 2'd2
  } ld_hq_state_e;

endpackage

// File: rtl/glb_ld_header_queue.sv
// Load-DMA header queue: config-written slots streamed in index order over valid/ready,
// with one-shot/loop modes, stop/clear abort, done pulse and completed-header counter.
module glb_ld_header_queue
  import global_buffer_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = LD_HQ_DEPTH,
  parameter int unsigned CNT_WIDTH   = LD_HQ_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(QUEUE_DEPTH)-1:0] cfg_wr_idx,
  input  dma_ld_header_t                 cfg_wr_hdr,
  input  logic                           cfg_clr,
  input  logic                           cfg_loop_en,
  input  logic                           strm_start,
  input  logic                           strm_stop,
  output logic                           hdr_valid,
  output dma_ld_header_t                 hdr,
  input  logic                           hdr_ready,
  output logic                           busy,
  output logic                           done_pulse,
  output logic                           cfg_err_pulse,
  output logic [CNT_WIDTH-1:0]           done_cnt
);

  localparam int unsigned IDX_W  = $clog2(QUEUE_DEPTH);
  localparam int unsigned MISS_W = IDX_W + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(QUEUE_DEPTH - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(QUEUE_DEPTH - 1);

  dma_ld_header_t slots [QUEUE_DEPTH];
  ld_hq_state_e   state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic done_d, err_d, wr_ok, advance, any_valid;

  assign hdr       = slots[ptr_q];
  assign hdr_valid = (state_q == OFFER);
  assign busy      = (state_q != IDLE);

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) any_valid = any_valid | slots[i].valid;
  end

  // Next state; miss_q counts consecutive empty slots so an emptied loop terminates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    miss_d  = miss_q;
    cnt_d   = done_cnt;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_ok   = 1'b0;
    advance = 1'b0;
    if (hdr_valid && hdr_ready) cnt_d = done_cnt + CNT_WIDTH'(1);
    if (cfg_clr) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      if (cfg_wr_en) begin
        if (busy && (cfg_wr_idx == ptr_q)) err_d = 1'b1;
        else                               wr_ok = 1'b1;
      end
      if (strm_stop && busy) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (strm_start) begin
              cnt_d = '0;
              if (any_valid) begin
                state_d = SCAN;
                ptr_d   = '0;
                miss_d  = '0;
              end else begin
                done_d = 1'b1;
              end
            end
          end
          SCAN: begin
            if (slots[ptr_q].valid) begin
              state_d = OFFER;
              miss_d  = '0;
            end else if (miss_q == MISS_LAST) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              miss_d  = miss_q + MISS_W'(1);
              advance = 1'b1;
            end
          end
          OFFER:   advance = hdr_ready;
          default: state_d = IDLE;
        endcase
        if (advance) begin
          if (ptr_q != LAST_IDX) begin
            ptr_d   = ptr_q + IDX_W'(1);
            state_d = SCAN;
          end else if (cfg_loop_en) begin
            ptr_d   = '0;
            state_d = SCAN;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      miss_q        <= '0;
      done_cnt      <= '0;
      done_pulse    <= 1'b0;
      cfg_err_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      miss_q        <= miss_d;
      done_cnt      <= cnt_d;
      done_pulse    <= done_d;
      cfg_err_pulse <= err_d;
    end
  end

  // Slot store: clear drops only the valid bits; other fields are kept verbatim.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) slots[i] <= '0;
    end else if (cfg_clr) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) slots[i].valid <= 1'b0;
    end else if (wr_ok) begin
      slots[cfg_wr_idx] <= cfg_wr_hdr;
    end
  end

endmodule
